hicore_bru_pred: RTL and testbench
==================================

# hicore_bru_pred

Parametrised branch resolution unit with dynamic prediction for the HiCore execute stage. Fetch queries a 2-bit-counter branch history table (BHT) combinationally. Execute resolves BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR, computes the link value, and compares the outcome against the prediction carried down the pipe. It then raises a registered redirect, trains the table, and keeps mispredict statistics.

## Interface
- XLEN, 32, datapath and PC width.
- BHT_DEPTH, 64, BHT entries; power of two, 4..1024; IDX = log2(BHT_DEPTH).
- CNT_W, 32, width of the performance counters.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- fe_pc  in  XLEN  fetch PC for prediction lookup.
- fe_pred_taken  out  1  prediction for fe_pc; combinational.
- ex_valid  in  1  instruction in execute this cycle; one cycle per instruction.
- ex_pc, ex_imm, ex_src1, ex_src2  in  XLEN each  PC, B/J/I immediate, rs1, rs2.
- ex_branch_msg  in  3  funct3.
- ex_branch_op, ex_jal_op, ex_jalr_op  in  1 each  opcode class; at most one is high.
- ex_pred_taken  in  1  prediction used at fetch.
- ex_pred_pc  in  XLEN  PC fetch followed.
- rd_result  out  XLEN  ex_pc+4 for JAL/JALR; combinational.
- redirect  out  1  registered flush/redirect pulse.
- redirect_pc  out  XLEN  registered correct next PC.
- misalign  out  1  registered; the taken target has bits [1:0] != 0.
- branch_cnt, mispred_cnt  out  CNT_W each  resolved control-flow count and mispredict count.

## Operation
- Resolution: target = ex_imm + (ex_jalr_op ? ex_src1 : ex_pc). For JALR, target[0] is forced to 0.
- Compare: one XLEN+1-bit subtract ex_src1 - ex_src2. The sign extension bit is 0 when funct3[1]=1 (unsigned compare). Zero result gives EQ. Bit XLEN gives LT.
- taken = jal | jalr | (branch_op & cond). Funct3 codes 010/011 on branch_op mean not taken.
- Actual next PC: act_pc = taken ? target : ex_pc+4.
- Mispredict: ex_valid & ((taken != ex_pred_taken) | (taken & ex_pred_pc != target)). This also covers a non-control instruction that was wrongly predicted taken; its redirect goes to ex_pc+4.
- Shadow kill: while redirect=1, ex_valid is ignored for every effect (no redirect, no training, no counting).
- Training: only on ex_valid & ex_branch_op. Index = ex_pc[IDX+1:2]. The counter saturates up if taken, down if not, with limits 00 and 11.
- Lookup: fe_pred_taken = bht[fe_pc[IDX+1:2]][1].
- Counters: branch_cnt increments on each accepted ex_valid with any of the three op flags set. mispred_cnt increments on each accepted mispredict. Both wrap modulo 2^CNT_W.
- Misalign: asserted with a redirect when target[1:0] != 0 and taken. redirect_pc still equals target; the trap unit owns the response.

## Timing
- Reset values: redirect=0, redirect_pc=0, misalign=0, branch_cnt=0, mispred_cnt=0, every BHT entry = 2'b01 (weakly not-taken).
- ex_valid in cycle N gives redirect, redirect_pc and misalign in cycle N+1, held for exactly 1 cycle.
- A BHT write occurs at the clock edge ending cycle N. A lookup in cycle N+1 sees the new value; there is no same-cycle bypass.
- Counter increments are visible in cycle N+1.
- Reset mid-operation: all state returns to its reset value immediately. A pending redirect is dropped.
- Back-to-back mispredicts in N and N+1: the N+1 instruction is killed by the shadow rule, so there is only one redirect.

## Configuration
- HICORE_BHT_EN defined: dynamic BHT as described above.
- HICORE_BHT_EN undefined: there is no table, and training and BHT_DEPTH are ignored. Prediction is static: fe_pred_taken = 0 for all PCs. Resolution, redirect and counters are unchanged.

## Structure
- The shared package hicore_pkg holds the funct3 constants (BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111) and the 2-bit counter typedef with its reset constant 2'b01.
- Sub-module hicore_bht: counter array, combinational read port, single write port (idx, taken, we), async reset of all entries. It is instantiated only under HICORE_BHT_EN.

## Test plan
- Reset, then fe_pc=0x100 → fe_pred_taken=0. redirect=0 and both counters are 0.
- BEQ at 0x100, src1=src2=5, imm=0x20, pred not-taken → next cycle redirect=1, redirect_pc=0x120, mispred_cnt=1. The same BEQ issued again predicts taken (entry now 10).
- BLTU src1=1, src2=0xFFFFFFFF vs BLT with the same operands → BLTU taken, BLT not taken. Correct predictions produce no redirect and branch_cnt=2.
- JALR src1=0x203, imm=0, pred_pc=0x200, pred_taken=1 → target 0x202. Mispredict: redirect_pc=0x202, misalign=1, rd_result=pc+4.
- Two consecutive mispredicting branches → only the first redirects, mispred_cnt increments by 1, and the second index is not trained.
- Train one entry taken four times → it saturates at 11. One not-taken outcome gives 10, and fe_pred_taken stays 1. Assert rst_n mid-sequence → the entry reads 01.

Source files
------------

// File: rtl/hicore_pkg.sv
// Shared HiCore definitions: branch funct3 codes and the 2-bit BHT counter type.
package hicore_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] bht_cnt_t;

  // Weakly not-taken.
  localparam bht_cnt_t BHT_CNT_RST = 2'b01;

  // Saturating 2-bit counter step: limits 00 and 11.
  function automatic bht_cnt_t bht_cnt_next(input bht_cnt_t cnt, input logic taken);
    bht_cnt_t nxt;
    nxt = cnt;
    if (taken && cnt != 2'b11) nxt = cnt + 2'b01;
    else if (!taken && cnt != 2'b00) nxt = cnt - 2'b01;
    return nxt;
  endfunction

endpackage

// File: rtl/hicore_bht.sv
// Branch history table: array of saturating 2-bit counters with one
// combinational read port and one write (training) port.
module hicore_bht
  import hicore_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int IDX  = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [IDX-1:0] rd_idx_i,
  output logic           rd_taken_o,
  input  logic           wr_en_i,
  input  logic [IDX-1:0] wr_idx_i,
  input  logic           wr_taken_i
);

  bht_cnt_t cnt_q [DEPTH];

  // NOTE: every entry must read weakly not-taken right after reset, so the
  // table is a resettable flop array rather than an unreset RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= BHT_CNT_RST;
    end else if (wr_en_i) begin
      cnt_q[wr_idx_i] <= bht_cnt_next(cnt_q[wr_idx_i], wr_taken_i);
    end
  end

  // No bypass: a write this cycle is visible to lookups from the next cycle.
  assign rd_taken_o = cnt_q[rd_idx_i][1];

endmodule

// File: rtl/hicore_bru_pred.sv
// HiCore execute-stage branch resolution unit with BHT prediction.
// Build option: define HICORE_BHT_EN for the dynamic BHT; otherwise static not-taken.
module hicore_bru_pred
  import hicore_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] fe_pc,
  output logic            fe_pred_taken,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_src1,
  input  logic [XLEN-1:0] ex_src2,
  input  logic [2:0]      ex_branch_msg,
  input  logic            ex_branch_op,
  input  logic            ex_jal_op,
  input  logic            ex_jalr_op,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_pc,
  output logic [XLEN-1:0] rd_result,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            misalign,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            misalign_q, misalign_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic            accept;
  logic            is_cf;
  logic [XLEN-1:0] tgt_sum, target, pc_plus4, act_pc;
  logic [XLEN:0]   diff;
  logic            cmp_eq, cmp_lt, cond, taken, mispredict;
  logic            sign1, sign2;

  // The instruction right behind a redirect is on the wrong path.
  assign accept = ex_valid & ~redirect_q;
  assign is_cf  = ex_branch_op | ex_jal_op | ex_jalr_op;

  assign tgt_sum  = ex_imm + (ex_jalr_op ? ex_src1 : ex_pc);
  assign target   = {tgt_sum[XLEN-1:1], tgt_sum[0] & ~ex_jalr_op};
  assign pc_plus4 = ex_pc + XLEN'(4);

  // One shared subtractor; funct3[1] selects unsigned by zeroing the extension bit.
  assign sign1  = ~ex_branch_msg[1] & ex_src1[XLEN-1];
  assign sign2  = ~ex_branch_msg[1] & ex_src2[XLEN-1];
  assign diff   = {sign1, ex_src1} - {sign2, ex_src2};
  assign cmp_eq = (diff[XLEN-1:0] == '0);
  assign cmp_lt = diff[XLEN];

  // NOTE: cond gets a default before the case so no latch is inferred.
  always_comb begin
    cond = 1'b0;
    case (ex_branch_msg)
      F3_BEQ:          cond = cmp_eq;
      F3_BNE:          cond = ~cmp_eq;
      F3_BLT, F3_BLTU: cond = cmp_lt;
      F3_BGE, F3_BGEU: cond = ~cmp_lt;
      default:         cond = 1'b0;
    endcase
  end

  assign taken      = ex_jal_op | ex_jalr_op | (ex_branch_op & cond);
  assign act_pc     = taken ? target : pc_plus4;
  assign mispredict = (taken != ex_pred_taken) | (taken & (ex_pred_pc != target));
  assign rd_result  = (ex_jal_op | ex_jalr_op) ? pc_plus4 : '0;

  assign redirect_d    = accept & mispredict;
  assign redirect_pc_d = redirect_d ? act_pc : '0;
  assign misalign_d    = redirect_d & taken & (target[1:0] != 2'b00);
  assign branch_cnt_d  = (accept & is_cf) ? branch_cnt_q + CNT_W'(1) : branch_cnt_q;
  assign mispred_cnt_d = redirect_d ? mispred_cnt_q + CNT_W'(1) : mispred_cnt_q;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      misalign_q    <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      misalign_q    <= misalign_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign misalign    = misalign_q;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

`ifdef HICORE_BHT_EN
  localparam int IDX = $clog2(BHT_DEPTH);

  hicore_bht #(.DEPTH(BHT_DEPTH)) u_bht (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_i   (fe_pc[IDX+1:2]),
    .rd_taken_o (fe_pred_taken),
    .wr_en_i    (accept & ex_branch_op),
    .wr_idx_i   (ex_pc[IDX+1:2]),
    .wr_taken_i (taken)
  );
`else
  assign fe_pred_taken = 1'b0;
`endif

  // Only the index bits of fe_pc matter (none without the BHT).
  logic unused_fe_pc;
  assign unused_fe_pc = ^fe_pc;

endmodule

// File: tb/tb_hicore_bru_pred.sv
// Scoreboard bench for hicore_bru_pred; works with or without HICORE_BHT_EN.
module tb_hicore_bru_pred;
  import hicore_pkg::*;

`ifdef HICORE_BHT_EN
  localparam bit BHT_EN = 1'b1;
`else
  localparam bit BHT_EN = 1'b0;
`endif

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_BR   = 3'b100;
  localparam logic [2:0] OP_JAL  = 3'b010;
  localparam logic [2:0] OP_JALR = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fe_pc;
  logic        fe_pred_taken;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_imm, ex_src1, ex_src2, ex_pred_pc;
  logic [2:0]  ex_branch_msg;
  logic        ex_branch_op, ex_jal_op, ex_jalr_op, ex_pred_taken;
  logic [31:0] rd_result, redirect_pc, branch_cnt, mispred_cnt;
  logic        redirect, misalign;

  hicore_bru_pred #(.XLEN(32), .BHT_DEPTH(64), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .fe_pc(fe_pc), .fe_pred_taken(fe_pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_src1(ex_src1),
    .ex_src2(ex_src2), .ex_branch_msg(ex_branch_msg), .ex_branch_op(ex_branch_op),
    .ex_jal_op(ex_jal_op), .ex_jalr_op(ex_jalr_op), .ex_pred_taken(ex_pred_taken),
    .ex_pred_pc(ex_pred_pc), .rd_result(rd_result), .redirect(redirect),
    .redirect_pc(redirect_pc), .misalign(misalign), .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        redir;
    logic [31:0] pc;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_run = 0;
  int unsigned n_fail = 0;

  logic [1:0]  m_bht [64];
  logic        m_redir;
  logic [31:0] m_branch, m_mispred;

  function automatic logic m_pred(input logic [31:0] pc);
    return BHT_EN ? m_bht[pc[7:2]][1] : 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
    m_redir = 1'b0;
    m_branch = '0;
    m_mispred = '0;
    sb.delete();
  endtask

  task automatic check_pred(input logic [31:0] pc, input string name);
    fe_pc = pc;
    #1;
    n_run++;
    if (fe_pred_taken !== m_pred(pc)) begin
      n_fail++;
      $display("FAIL %s: fe_pred_taken=%0b expected %0b", name, fe_pred_taken, m_pred(pc));
    end
  endtask

  // One execute cycle: drive, predict expectation, push, clock, pop and compare.
  task automatic cycle(input logic v, input logic [2:0] op, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] s1, input logic [31:0] s2,
                       input logic pt, input logic [31:0] ppc, input string name);
    logic [31:0] tgt, p4, act;
    logic cnd, tk, misp, acc;
    exp_t e, got;
    @(negedge clk);
    ex_valid = v; {ex_branch_op, ex_jal_op, ex_jalr_op} = op;
    ex_branch_msg = f3; ex_pc = pc; ex_imm = imm; ex_src1 = s1; ex_src2 = s2;
    ex_pred_taken = pt; ex_pred_pc = ppc;
    case (f3)
      3'b000:  cnd = (s1 == s2);
      3'b001:  cnd = (s1 != s2);
      3'b100:  cnd = ($signed(s1) <  $signed(s2));
      3'b101:  cnd = ($signed(s1) >= $signed(s2));
      3'b110:  cnd = (s1 <  s2);
      3'b111:  cnd = (s1 >= s2);
      default: cnd = 1'b0;
    endcase
    tgt = imm + (op[0] ? s1 : pc);
    if (op[0]) tgt[0] = 1'b0;
    p4   = pc + 32'd4;
    tk   = op[1] | op[0] | (op[2] & cnd);
    act  = tk ? tgt : p4;
    misp = (tk != pt) | (tk & (ppc != tgt));
    acc  = v & ~m_redir;
    e.redir = acc & misp;
    e.pc    = e.redir ? act : 32'd0;
    e.mis   = e.redir & tk & (tgt[1:0] != 2'b00);
    sb.push_back(e);
    check_pred(pc, {name, "_pred"});
    if (v && (op[1] || op[0])) begin
      n_run++;
      if (rd_result !== p4) begin
        n_fail++;
        $display("FAIL %s_link: rd_result=%h expected %h", name, rd_result, p4);
      end
    end
    @(posedge clk);
    #1;
    if (acc) begin
      if (op != OP_NONE) m_branch++;
      if (misp) m_mispred++;
      if (op[2]) begin
        if (tk && m_bht[pc[7:2]] != 2'b11) m_bht[pc[7:2]]++;
        else if (!tk && m_bht[pc[7:2]] != 2'b00) m_bht[pc[7:2]]--;
      end
    end
    m_redir = e.redir;
    got = sb.pop_front();
    n_run++;
    if (redirect !== got.redir || (got.redir && redirect_pc !== got.pc) || misalign !== got.mis) begin
      n_fail++;
      $display("FAIL %s_redir: redirect=%0b pc=%h misalign=%0b expected %0b %h %0b",
               name, redirect, redirect_pc, misalign, got.redir, got.pc, got.mis);
    end
    n_run++;
    if (branch_cnt !== m_branch || mispred_cnt !== m_mispred) begin
      n_fail++;
      $display("FAIL %s_cnt: branch_cnt=%0d mispred_cnt=%0d expected %0d %0d",
               name, branch_cnt, mispred_cnt, m_branch, m_mispred);
    end
  endtask

  task automatic idle(input string name);
    cycle(1'b0, OP_NONE, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ex_valid = 1'b0; fe_pc = 32'h100;
    {ex_branch_op, ex_jal_op, ex_jalr_op} = 3'b000; ex_branch_msg = 3'b000;
    ex_pc = '0; ex_imm = '0; ex_src1 = '0; ex_src2 = '0; ex_pred_taken = 1'b0; ex_pred_pc = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_pred(32'h100, "reset_pred");
    n_run++;
    if (redirect !== 1'b0 || branch_cnt !== 32'd0 || mispred_cnt !== 32'd0 || misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: redirect=%0b misalign=%0b branch_cnt=%0d mispred_cnt=%0d expected all 0",
               redirect, misalign, branch_cnt, mispred_cnt);
    end
  endtask

  task automatic test_beq();
    cycle(1'b1, OP_BR, F3_BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'h104, "beq_first");
    idle("beq_gap");
    check_pred(32'h100, "beq_retrained");
    cycle(1'b1, OP_BR, F3_BEQ, 32'h100, 32'h20, 32'd5, 32'd5, m_pred(32'h100), 32'h120, "beq_again");
    idle("beq_gap2");
  endtask

  task automatic test_compare();
    cycle(1'b1, OP_BR, F3_BLTU, 32'h180, 32'h40, 32'd1, 32'hFFFF_FFFF, 1'b1, 32'h1C0, "bltu");
    cycle(1'b1, OP_BR, F3_BLT,  32'h184, 32'h40, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'h188, "blt");
    cycle(1'b1, OP_BR, F3_BGE,  32'h188, 32'h40, 32'h8000_0000, 32'd3, 1'b0, 32'h18C, "bge_neg");
    cycle(1'b1, OP_BR, F3_BNE,  32'h18C, 32'hFFFF_FFF0, 32'd7, 32'd9, 1'b1, 32'h17C, "bne");
    cycle(1'b1, OP_BR, 3'b010,  32'h190, 32'h40, 32'd1, 32'd1, 1'b0, 32'h194, "f3_010");
    cycle(1'b1, OP_NONE, 3'b000, 32'h194, 32'h0, 32'd0, 32'd0, 1'b1, 32'h300, "nonbr_pt");
    idle("cmp_gap");
  endtask

  task automatic test_jump();
    cycle(1'b1, OP_JALR, 3'b000, 32'h500, 32'h0, 32'h203, 32'h0, 1'b1, 32'h200, "jalr_mis");
    idle("jmp_gap");
    cycle(1'b1, OP_JAL, 3'b000, 32'h504, 32'h100, 32'h0, 32'h0, 1'b1, 32'h604, "jal_ok");
    cycle(1'b1, OP_JAL, 3'b000, 32'h508, 32'h100, 32'h0, 32'h0, 1'b0, 32'h50C, "jal_mis");
    idle("jmp_gap2");
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, OP_BR, F3_BEQ, 32'h300, 32'h40, 32'd2, 32'd2, 1'b0, 32'h304, "b2b_first");
    cycle(1'b1, OP_BR, F3_BEQ, 32'h340, 32'h40, 32'd3, 32'd3, 1'b0, 32'h344, "b2b_second");
    idle("b2b_gap");
    check_pred(32'h340, "b2b_untrained");
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 4; i++)
      cycle(1'b1, OP_BR, F3_BEQ, 32'h400, 32'h10, 32'd7, 32'd7, m_pred(32'h400), 32'h410, "sat_up");
    idle("sat_gap");
    cycle(1'b1, OP_BR, F3_BEQ, 32'h400, 32'h10, 32'd7, 32'd8, m_pred(32'h400), 32'h410, "sat_down");
    idle("sat_gap2");
    check_pred(32'h400, "sat_still_taken");
    cycle(1'b1, OP_BR, F3_BNE, 32'h440, 32'h10, 32'd1, 32'd2, 1'b0, 32'h444, "pre_reset");
    rst_n = 1'b0;
    ex_valid = 1'b0;
    model_reset();
    #1;
    n_run++;
    if (redirect !== 1'b0 || misalign !== 1'b0 || branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL midreset_state: redirect=%0b misalign=%0b branch_cnt=%0d mispred_cnt=%0d expected all 0",
               redirect, misalign, branch_cnt, mispred_cnt);
    end
    check_pred(32'h400, "midreset_entry");
    @(negedge clk);
    rst_n = 1'b1;
    idle("post_reset");
    cycle(1'b1, OP_BR, F3_BEQ, 32'h400, 32'h10, 32'd7, 32'd7, 1'b1, 32'h410, "post_reset_br");
    idle("post_reset_gap");
  endtask

  initial begin
    test_reset();
    test_beq();
    test_compare();
    test_jump();
    test_back_to_back();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
